// File: rtl/param_queue_pkg.sv
// rtl/param_queue_pkg.sv - shared widths, helpers and parameter checks for param_queue
package param_queue_pkg;

    // Per-cycle handshake decode shared by storage, pointer and occupancy logic.
    typedef struct packed {
        logic do_flow;
        logic fire_enq;
        logic fire_deq;
        logic do_enq;
        logic do_deq;
    } queue_ctrl_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A single-entry queue still needs a one-bit pointer that is simply held at 0.
    function automatic int ptr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic bit params_legal(input int width, input int depth);
        return (width >= 1) && (depth >= 1);
    endfunction

endpackage

// File: rtl/param_queue_wrap_counter.sv
// rtl/param_queue_wrap_counter.sv - modulo-MODULUS pointer counter used for enq/deq pointers
module param_queue_wrap_counter #(
    parameter int W       = 1,
    parameter int MODULUS = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] value
);

    // With MODULUS=1 the last index is 0, so the counter never leaves 0.
    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == LAST) ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/param_queue.sv
// rtl/param_queue.sv - parametrised ready/valid FIFO with optional pipe and flow modes
module param_queue
    import param_queue_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 2,
    parameter int  PIPE  = 0,
    parameter int  FLOW  = 0,
    localparam int PW    = ptr_width(DEPTH),
    localparam int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic [CW-1:0]    count
);

    generate
        if (!params_legal(WIDTH, DEPTH)) begin : g_illegal
            $error("param_queue: WIDTH and DEPTH must both be at least 1");
        end
    endgenerate

    localparam logic PIPE_EN = (PIPE != 0);
    localparam logic FLOW_EN = (FLOW != 0);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    enq_ptr;
    logic [PW-1:0]    deq_ptr;
    logic             maybe_full;
    logic             ptr_match;
    logic             empty;
    logic             full;
    queue_ctrl_t      ctrl;
    logic [CW-1:0]    ptr_diff;

    assign ptr_match = (enq_ptr == deq_ptr);
    assign empty     = ptr_match & ~maybe_full;
    assign full      = ptr_match & maybe_full;

    assign enq_ready = ~full | (PIPE_EN & deq_ready);
    assign deq_valid = ~empty | (FLOW_EN & enq_valid);
    assign deq_bits  = (FLOW_EN & empty) ? enq_bits : storage[deq_ptr];

    // A flowed beat bypasses storage entirely, so it must not move either pointer.
    always_comb begin
        ctrl          = '0;
        ctrl.do_flow  = FLOW_EN & empty & deq_ready;
        ctrl.fire_enq = enq_valid & enq_ready;
        ctrl.fire_deq = deq_valid & deq_ready;
        ctrl.do_enq   = ctrl.fire_enq & ~ctrl.do_flow;
        ctrl.do_deq   = ctrl.fire_deq & ~ctrl.do_flow;
    end

    always_ff @(posedge clk) begin
        if (ctrl.do_enq) begin
            storage[enq_ptr] <= enq_bits;
        end
    end

    param_queue_wrap_counter #(
        .W       (PW),
        .MODULUS (DEPTH)
    ) u_enq_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl.do_enq),
        .value (enq_ptr)
    );

    param_queue_wrap_counter #(
        .W       (PW),
        .MODULUS (DEPTH)
    ) u_deq_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl.do_deq),
        .value (deq_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            maybe_full <= 1'b0;
        end else if (ctrl.do_enq != ctrl.do_deq) begin
            maybe_full <= ctrl.do_enq;
        end
    end

    // CW bits always hold 0..DEPTH, so the modular subtract plus wrap correction is exact.
    always_comb begin
        ptr_diff = CW'(enq_ptr) - CW'(deq_ptr);
        if (enq_ptr < deq_ptr) begin
            ptr_diff = ptr_diff + CW'(DEPTH);
        end
        if (ptr_match) begin
            count = maybe_full ? CW'(DEPTH) : '0;
        end else begin
            count = ptr_diff;
        end
    end

endmodule

// File: tb/tb_param_queue.sv
// tb/tb_param_queue.sv - self-checking bench for param_queue across several configurations
module tb_param_queue;

    localparam int NI = 5;
    localparam int DEPTHS [NI] = '{3, 2, 2, 1, 3};
    localparam int PIPES  [NI] = '{0, 1, 0, 0, 1};
    localparam int FLOWS  [NI] = '{0, 0, 1, 0, 1};

    logic       clk = 1'b0;
    logic       reset;
    logic       ev  [NI];
    logic       dr  [NI];
    logic       er  [NI];
    logic       dv  [NI];
    logic [7:0] eb  [NI];
    logic [7:0] db  [NI];
    logic [7:0] cnt [NI];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mq [NI][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int CWG = $clog2(DEPTHS[g] + 1);
        logic [CWG-1:0] c;
        param_queue #(
            .WIDTH (8),
            .DEPTH (DEPTHS[g]),
            .PIPE  (PIPES[g]),
            .FLOW  (FLOWS[g])
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .enq_valid (ev[g]),
            .enq_ready (er[g]),
            .enq_bits  (eb[g]),
            .deq_valid (dv[g]),
            .deq_ready (dr[g]),
            .deq_bits  (db[g]),
            .count     (c)
        );
        assign cnt[g] = 8'(c);
    end

    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got 0x%0h, expected 0x%0h", name, inst, $time, act, exp);
        end
    endtask

    // Reference queue: outputs from occupancy, then apply this cycle's transfers.
    always @(negedge clk) begin
        int n;
        bit x_er;
        bit x_dv;
        for (int i = 0; i < NI; i++) begin
            n    = mq[i].size();
            x_er = (n < DEPTHS[i]) || ((PIPES[i] != 0) && dr[i]);
            x_dv = (n > 0) || ((FLOWS[i] != 0) && ev[i]);
            chk("enq_ready", i, int'(er[i]), int'(x_er));
            chk("deq_valid", i, int'(dv[i]), int'(x_dv));
            chk("count", i, int'(cnt[i]), n);
            if (x_dv) begin
                chk("deq_bits", i, int'(db[i]), (n > 0) ? int'(mq[i][0]) : int'(eb[i]));
            end
            if (reset) begin
                mq[i].delete();
            end else if (!(n == 0 && FLOWS[i] != 0 && ev[i] && dr[i])) begin
                if (x_dv && dr[i]) begin
                    void'(mq[i].pop_front());
                end
                if (ev[i] && x_er) begin
                    mq[i].push_back(eb[i]);
                end
            end
        end
    end

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            ev[i] = 1'b0;
            dr[i] = 1'b0;
            eb[i] = 8'h00;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle_all();
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_enq_ready", 0, int'(er[0]), 1);
        chk("rst_deq_valid", 0, int'(dv[0]), 0);
        chk("rst_count", 0, int'(cnt[0]), 0);
        chk("rst_flow_deq_valid", 2, int'(dv[2]), 0);

        // DEPTH=3 fill then drain
        for (int k = 0; k < 3; k++) begin
            ev[0] = 1'b1;
            eb[0] = 8'(8'h11 * (k + 1));
            step();
        end
        ev[0] = 1'b0;
        #1;
        chk("fill_count", 0, int'(cnt[0]), 3);
        chk("fill_enq_ready", 0, int'(er[0]), 0);
        dr[0] = 1'b1;
        #1;
        chk("drain0", 0, int'(db[0]), 8'h11);
        step();
        #1;
        chk("drain1", 0, int'(db[0]), 8'h22);
        step();
        #1;
        chk("drain2", 0, int'(db[0]), 8'h33);
        step();
        dr[0] = 1'b0;
        #1;
        chk("drained_count", 0, int'(cnt[0]), 0);
        chk("drained_valid", 0, int'(dv[0]), 0);

        // DEPTH=3 streaming, pointers wrap
        for (int k = 0; k < 10; k++) begin
            ev[0] = 1'b1;
            dr[0] = 1'b1;
            eb[0] = 8'(k);
            #1;
            if (k > 0) begin
                chk("stream_bits", 0, int'(db[0]), k - 1);
                chk("stream_count", 0, int'(cnt[0]), 1);
            end
            step();
        end
        ev[0] = 1'b0;
        step();
        dr[0] = 1'b0;

        // DEPTH=2 PIPE: enqueue while full
        ev[1] = 1'b1;
        eb[1] = 8'hA0;
        step();
        eb[1] = 8'hA1;
        step();
        eb[1] = 8'hA2;
        dr[1] = 1'b1;
        #1;
        chk("pipe_enq_ready", 1, int'(er[1]), 1);
        chk("pipe_head", 1, int'(db[1]), 8'hA0);
        step();
        ev[1] = 1'b0;
        #1;
        chk("pipe_count", 1, int'(cnt[1]), 2);
        chk("pipe_next", 1, int'(db[1]), 8'hA1);
        step();
        #1;
        chk("pipe_last", 1, int'(db[1]), 8'hA2);
        step();
        dr[1] = 1'b0;

        // FLOW: pass-through then store
        ev[2] = 1'b1;
        eb[2] = 8'h5C;
        dr[2] = 1'b1;
        #1;
        chk("flow_valid", 2, int'(dv[2]), 1);
        chk("flow_bits", 2, int'(db[2]), 8'h5C);
        chk("flow_count", 2, int'(cnt[2]), 0);
        step();
        dr[2] = 1'b0;
        #1;
        chk("flow_store_valid", 2, int'(dv[2]), 1);
        step();
        ev[2] = 1'b0;
        #1;
        chk("flow_store_count", 2, int'(cnt[2]), 1);
        dr[2] = 1'b1;
        step();
        dr[2] = 1'b0;

        // DEPTH=1 alternate enqueue / dequeue
        for (int k = 1; k <= 4; k++) begin
            ev[3] = 1'b1;
            eb[3] = 8'(k);
            step();
            ev[3] = 1'b0;
            #1;
            chk("d1_enq_ready", 3, int'(er[3]), 0);
            chk("d1_count", 3, int'(cnt[3]), 1);
            chk("d1_bits", 3, int'(db[3]), k);
            dr[3] = 1'b1;
            step();
            dr[3] = 1'b0;
            #1;
            chk("d1_empty", 3, int'(cnt[3]), 0);
        end

        // Reset mid-operation
        ev[0] = 1'b1;
        eb[0] = 8'h61;
        step();
        eb[0] = 8'h62;
        step();
        ev[0] = 1'b0;
        #1;
        chk("pre_rst_count", 0, int'(cnt[0]), 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_count", 0, int'(cnt[0]), 0);
        chk("post_rst_valid", 0, int'(dv[0]), 0);
        chk("post_rst_ready", 0, int'(er[0]), 1);
        ev[0] = 1'b1;
        eb[0] = 8'h7E;
        step();
        ev[0] = 1'b0;
        dr[0] = 1'b1;
        #1;
        chk("post_rst_first", 0, int'(db[0]), 8'h7E);
        step();
        dr[0] = 1'b0;

        // Randomised traffic with varying pressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                ev[i] = ($urandom_range(0, 3) < ((c / 500) % 4 + 1)) ? 1'b1 : 1'b0;
                dr[i] = ($urandom_range(0, 3) < (3 - (c / 500) % 3)) ? 1'b1 : 1'b0;
                eb[i] = 8'($urandom);
            end
            reset = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
            step();
        end
        reset = 1'b0;
        idle_all();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
